nanci_pe_seq: RTL and testbench

- Parametrised successor to the Nanci mesh processing element's fixed neighbour-select behaviour.
- Holds one key/data word and runs a small stored program of neighbour operations, one instruction per step: select, compare-exchange min, compare-exchange max, load MAX_INT, and no-op.
- Generalises the fixed four-neighbour PE to NUM_PORTS neighbours, with programmable step latency and pass repetition.
- Sits in each mesh cell; o_PE feeds the neighbours' input bus.

---
 rtl/nanci_pe_seq.sv | 154 +++++++++++++++
 tb/tb_nanci_pe_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nanci_pe_seq.sv
// Nanci mesh processing element with a small stored program of neighbour
// operations (select, compare-exchange min/max, load max, no-op).
//
// state | meaning
// IDLE  | program writable, waiting for start, o_PE holds
// RUN   | stepping through prog_len slots for repeat_cnt+1 passes
module nanci_pe_seq #(
    parameter int ADDR_WIDTH  = 3,
    parameter int DATA_WIDTH  = 3,
    parameter int NUM_PORTS   = 4,
    parameter int PROG_DEPTH  = 8,
    parameter int STEP_CYCLES = 1,
    parameter int REPEAT_W    = 4,
    parameter logic [ADDR_WIDTH+DATA_WIDTH-1:0] MAX_INT   = '1,
    parameter logic [ADDR_WIDTH+DATA_WIDTH-1:0] RST_VALUE = '0,
    localparam int W  = ADDR_WIDTH + DATA_WIDTH,
    localparam int PA = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1,
    localparam int LW = $clog2(PROG_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_PORTS*W-1:0] i_PE_nbr,
    input  logic                   prog_we,
    input  logic [PA-1:0]          prog_addr,
    input  logic [6:0]             prog_wdata,
    input  logic [LW-1:0]          prog_len,
    input  logic [REPEAT_W-1:0]    repeat_cnt,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [W-1:0]           o_PE
);

    localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [2:0] OP_SLT   = 3'd1;
    localparam logic [2:0] OP_CMIN  = 3'd2;
    localparam logic [2:0] OP_CMAX  = 3'd3;
    localparam logic [2:0] OP_LOADI = 3'd4;

    logic [0:0]          state;
    logic [6:0]          prog_mem [PROG_DEPTH];
    logic [PA-1:0]       pc;
    logic [LW-1:0]       len_q;
    logic [REPEAT_W-1:0] pass_q;
    logic [TW-1:0]       tmr;
    logic                drain;

    logic [6:0]    instr;
    logic [W-1:0]  nbr;
    logic [W-1:0]  step_result;
    logic [LW-1:0] len_clamp;
    logic          last_slot;
    logic          last_step;

    assign busy      = (state == RUN);
    assign instr     = prog_mem[pc];
    assign len_clamp = (prog_len > LW'(PROG_DEPTH)) ? LW'(PROG_DEPTH) : prog_len;
    assign last_slot = ((LW'(pc) + LW'(1)) == len_q);
    assign last_step = last_slot && (pass_q == '0);

    // Neighbour select; unused port indices read as MAX_INT.
    always_comb begin
        nbr = MAX_INT;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (instr[3:0] == 4'(k)) nbr = i_PE_nbr[k*W +: W];
        end
    end

    // Result of the current instruction; ties and unknown ops keep the own word.
    always_comb begin
        step_result = o_PE;
        case (instr[6:4])
            OP_SLT:   step_result = nbr;
            OP_CMIN:  if (nbr[W-1 -: ADDR_WIDTH] < o_PE[W-1 -: ADDR_WIDTH]) step_result = nbr;
            OP_CMAX:  if (nbr[W-1 -: ADDR_WIDTH] > o_PE[W-1 -: ADDR_WIDTH]) step_result = nbr;
            OP_LOADI: step_result = MAX_INT;
            default:  step_result = o_PE;
        endcase
    end

    // Sequencer: program load, step timing, pass repetition and completion pulse.
    // After the last step the timer drains so done lands STEP_CYCLES-1 edges later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pc     <= '0;
            len_q  <= '0;
            pass_q <= '0;
            tmr    <= '0;
            drain  <= 1'b0;
            done   <= 1'b0;
            o_PE   <= RST_VALUE;
            for (int j = 0; j < PROG_DEPTH; j++) prog_mem[j] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (prog_we && (int'(prog_addr) < PROG_DEPTH)) prog_mem[prog_addr] <= prog_wdata;
                    if (start) begin
                        state  <= RUN;
                        len_q  <= len_clamp;
                        pass_q <= repeat_cnt;
                        pc     <= '0;
                        tmr    <= '0;
                        drain  <= 1'b0;
                    end
                end
                default: begin
                    if (drain) begin
                        if (tmr == TW'(1)) begin
                            state <= IDLE;
                            done  <= 1'b1;
                            pc    <= '0;
                            drain <= 1'b0;
                        end else begin
                            tmr <= tmr - TW'(1);
                        end
                    end else if (tmr != '0) begin
                        tmr <= tmr - TW'(1);
                    end else if (len_q == '0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                        pc    <= '0;
                    end else begin
                        o_PE <= step_result;
                        if (last_step) begin
                            if (STEP_CYCLES == 1) begin
                                state <= IDLE;
                                done  <= 1'b1;
                                pc    <= '0;
                            end else begin
                                drain <= 1'b1;
                                tmr   <= TW'(STEP_CYCLES - 1);
                            end
                        end else begin
                            tmr <= TW'(STEP_CYCLES - 1);
                            if (last_slot) begin
                                pc     <= '0;
                                pass_q <= pass_q - REPEAT_W'(1);
                            end else begin
                                pc <= pc + PA'(1);
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nanci_pe_seq.sv
// Scoreboard bench for nanci_pe_seq: instance 0 uses one cycle per step,
// instance 1 uses two. Expected final words and done cycles are queued at
// start time and matched by a monitor on each done pulse.
module tb_nanci_pe_seq;

    logic        clk = 1'b0;
    logic        rst_v   [2];
    logic [23:0] nbr_v   [2];
    logic        we_v    [2];
    logic [2:0]  addr_v  [2];
    logic [6:0]  wd_v    [2];
    logic [3:0]  len_v   [2];
    logic [3:0]  rep_v   [2];
    logic        start_v [2];
    logic        busy_v  [2];
    logic        done_v  [2];
    logic [5:0]  ope_v   [2];

    typedef struct {
        logic [5:0] ope;
        int         cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    logic [6:0] mdl_mem [2][8];
    logic [5:0] mdl_ope [2];
    int cyc   = 0;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nanci_pe_seq #(.STEP_CYCLES(1)) u_dut0 (
        .clk(clk), .rst(rst_v[0]), .i_PE_nbr(nbr_v[0]), .prog_we(we_v[0]),
        .prog_addr(addr_v[0]), .prog_wdata(wd_v[0]), .prog_len(len_v[0]),
        .repeat_cnt(rep_v[0]), .start(start_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .o_PE(ope_v[0])
    );

    nanci_pe_seq #(.STEP_CYCLES(2)) u_dut1 (
        .clk(clk), .rst(rst_v[1]), .i_PE_nbr(nbr_v[1]), .prog_we(we_v[1]),
        .prog_addr(addr_v[1]), .prog_wdata(wd_v[1]), .prog_len(len_v[1]),
        .repeat_cnt(rep_v[1]), .start(start_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .o_PE(ope_v[1])
    );

    // Reference: run the whole program as plain arithmetic over passes and slots.
    function automatic logic [5:0] model_run(input int i, input int len, input int rep,
                                             input logic [23:0] nbr, input logic [5:0] ope);
        logic [5:0] w;
        logic [5:0] v;
        logic [6:0] ins;
        int sel;
        int n;
        w = ope;
        n = (len > 8) ? 8 : len;
        for (int p = 0; p <= rep; p++) begin
            for (int s = 0; s < n; s++) begin
                ins = mdl_mem[i][s];
                sel = int'(ins[3:0]);
                v = (sel < 4) ? nbr[sel*6 +: 6] : 6'h3f;
                case (int'(ins[6:4]))
                    1: w = v;
                    2: if (v[5:3] < w[5:3]) w = v;
                    3: if (v[5:3] > w[5:3]) w = v;
                    4: w = 6'h3f;
                    default: ;
                endcase
            end
        end
        return w;
    endfunction

    function automatic void model_reset(input int i);
        for (int s = 0; s < 8; s++) mdl_mem[i][s] = '0;
        mdl_ope[i] = 6'h00;
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    // Monitor: every done pulse must match the oldest expected completion.
    always @(negedge clk) begin
        exp_t e;
        bit   have;
        for (int i = 0; i < 2; i++) begin
            if (done_v[i] === 1'b1) begin
                have = 1'b0;
                if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                tests++;
                if (!have) begin
                    fails++;
                    $display("FAIL unexpected_done inst%0d: done=1 at cycle %0d, none expected", i, cyc);
                end else if (ope_v[i] !== e.ope || cyc != e.cyc || busy_v[i] !== 1'b0) begin
                    fails++;
                    $display("FAIL done_result inst%0d: o_PE=%0h cyc=%0d busy=%b expected o_PE=%0h cyc=%0d busy=0",
                             i, ope_v[i], cyc, busy_v[i], e.ope, e.cyc);
                end
            end
        end
    end

    task automatic wr(input int i, input int a, input logic [6:0] w);
        @(negedge clk);
        we_v[i]   = 1'b1;
        addr_v[i] = 3'(a);
        wd_v[i]   = w;
        @(negedge clk);
        we_v[i] = 1'b0;
        mdl_mem[i][a] = w;
    endtask

    // mode 0: normal, 1: start/prog_we pulsed while busy, 2: rst before third edge
    task automatic do_run(input int i, input int len, input int rep, input logic [23:0] nbr, input int mode);
        exp_t e;
        int   t;
        int   d;
        bit   ok;
        @(negedge clk);
        nbr_v[i]   = nbr;
        len_v[i]   = 4'(len);
        rep_v[i]   = 4'(rep);
        start_v[i] = 1'b1;
        t = ((len > 8) ? 8 : len) * (rep + 1);
        d = (t == 0) ? 1 : t * (i + 1);
        e.ope = model_run(i, len, rep, nbr, mdl_ope[i]);
        e.cyc = cyc + 1 + d;
        if (mode != 2) begin
            mdl_ope[i] = e.ope;
            if (i == 0) q0.push_back(e); else q1.push_back(e);
        end
        @(negedge clk);
        start_v[i] = 1'b0;
        if (mode == 1) begin
            @(negedge clk);
            start_v[i] = 1'b1;
            we_v[i]    = 1'b1;
            addr_v[i]  = 3'd0;
            wd_v[i]    = {3'd4, 4'd0};
            @(negedge clk);
            start_v[i] = 1'b0;
            we_v[i]    = 1'b0;
        end
        if (mode == 2) begin
            @(negedge clk);
            rst_v[i] = 1'b1;
            @(negedge clk);
            rst_v[i] = 1'b0;
            check("midrun_rst_ope", 32'(ope_v[i]), 32'h0);
            check("midrun_rst_busy", 32'(busy_v[i]), 32'h0);
            model_reset(i);
            repeat (12) @(negedge clk);
        end else begin
            ok = 1'b0;
            for (int k = 0; k < 500; k++) begin
                if (busy_v[i] === 1'b0) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            if (!ok) begin
                tests++;
                fails++;
                $display("FAIL busy_timeout inst%0d: busy still 1 after 500 cycles, expected 0", i);
            end
            @(negedge clk);
        end
    endtask

    localparam logic [23:0] NBR_A = {6'h20, 6'h18, 6'h10, 6'h08};
    localparam logic [23:0] NBR_T = {6'h20, 6'h18, 6'h10, 6'h1f};

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_v[i] = 1'b1; nbr_v[i] = '0; we_v[i] = 1'b0; addr_v[i] = '0;
            wd_v[i] = '0; len_v[i] = '0; rep_v[i] = '0; start_v[i] = 1'b0;
            model_reset(i);
        end
        repeat (3) @(negedge clk);
        rst_v[0] = 1'b0;
        rst_v[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("reset_ope", 32'(ope_v[i]), 32'h0);
            check("reset_busy", 32'(busy_v[i]), 32'h0);
            check("reset_done", 32'(done_v[i]), 32'h0);
        end

        // empty program, neighbours non-zero
        do_run(0, 8, 0, 24'hfedcba, 0);
        // directed neighbour ops
        wr(0, 0, {3'd1, 4'd2});
        do_run(0, 1, 0, NBR_A, 0);
        wr(0, 0, {3'd1, 4'd0}); wr(0, 1, {3'd3, 4'd1}); wr(0, 2, {3'd3, 4'd2}); wr(0, 3, {3'd3, 4'd3});
        do_run(0, 4, 0, NBR_A, 0);
        wr(0, 0, {3'd2, 4'd0}); wr(0, 1, {3'd2, 4'd1}); wr(0, 2, {3'd2, 4'd2}); wr(0, 3, {3'd2, 4'd3});
        do_run(0, 4, 0, NBR_A, 0);
        wr(0, 0, {3'd1, 4'd2}); wr(0, 1, {3'd2, 4'd0});
        do_run(0, 2, 0, NBR_T, 0);
        wr(0, 0, {3'd2, 4'd5});
        do_run(0, 1, 0, NBR_T, 0);
        wr(0, 0, {3'd6, 4'd1});
        do_run(0, 1, 0, NBR_T, 0);
        wr(0, 0, {3'd1, 4'd5});
        do_run(0, 1, 0, NBR_T, 0);
        wr(0, 0, {3'd1, 4'd0}); wr(0, 1, {3'd4, 4'd0});
        do_run(0, 2, 0, NBR_T, 0);
        do_run(0, 1, 0, NBR_A, 0);
        do_run(0, 0, 2, NBR_A, 0);

        // two-cycle steps, repeat, ignored start/prog_we while busy
        wr(1, 0, {3'd1, 4'd1});
        do_run(1, 1, 1, NBR_A, 1);
        do_run(1, 1, 0, {6'h20, 6'h18, 6'h2a, 6'h08}, 0);
        do_run(1, 0, 0, NBR_A, 0);

        // reset part-way through a 4-step run, then a fresh run sees empty slots
        wr(0, 0, {3'd1, 4'd3}); wr(0, 1, {3'd1, 4'd2}); wr(0, 2, {3'd1, 4'd1}); wr(0, 3, {3'd1, 4'd0});
        do_run(0, 4, 0, NBR_A, 2);
        do_run(0, 4, 0, NBR_A, 0);

        // random programs on both instances
        for (int n = 0; n < 24; n++) begin
            int i;
            int ns;
            i  = n % 2;
            ns = $urandom_range(0, 3);
            for (int s = 0; s < ns; s++)
                wr(i, $urandom_range(0, 7), 7'({$urandom_range(0, 7), $urandom_range(0, 15)} & 32'h7f));
            do_run(i, $urandom_range(0, 9), $urandom_range(0, 3), 24'($urandom), 0);
        end

        repeat (4) @(negedge clk);
        check("q0_drained", 32'(q0.size()), 32'h0);
        check("q1_drained", 32'(q1.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
